// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller for a dual-port buffer memory.
// Turns push/pop requests into memory write/read strobes and addresses.
// Also tracks occupancy, reports full/empty/almost flags and sticky error flags,
// and raises data_valid in the cycle the memory's registered read data holds popped data.
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [ADDR_WIDTH:0]   af_threshold,
   input  logic [ADDR_WIDTH:0]   ae_threshold,
   output logic                  write,
   output logic                  read,
   output logic [ADDR_WIDTH-1:0] addressW,
   output logic [ADDR_WIDTH-1:0] addressR,
   output logic                  data_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   // Occupancy value that means every entry is in use.
   localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(MEM_LENGTH);

   // Highest legal address; pointers wrap to zero after it.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_LENGTH - 1);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] wr_ptr_next;
   logic [ADDR_WIDTH-1:0] rd_ptr_next;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  push_ok;
   logic                  pop_ok;

   // Full and empty come from the occupancy counter.
   // Equal pointers cannot tell full apart from empty.
   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

   // A request is accepted only when there is room or data for it.
   // When both requests arrive together, the full/empty checks decide
   // which one is dropped.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // The strobes and addresses are combinational.
   // The memory samples them on the same edge that advances the pointers.
   assign write    = push_ok;
   assign read     = pop_ok;
   assign addressW = wr_ptr;
   assign addressR = rd_ptr;

   // The watermark flags follow the occupancy and the live threshold inputs.
   // They change in the same cycle as either one.
   assign almost_full  = (count >= af_threshold);
   assign almost_empty = (count <= ae_threshold);

   // Next pointer values: advance on an accepted request, wrapping after the last entry.
   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      if (push_ok) begin
         wr_ptr_next = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_next = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
      end
   end

   // Next occupancy: a push alone adds one, a pop alone removes one, and both together cancel.
   // Acceptance gating keeps the count within 0..MEM_LENGTH.
   always_comb begin
      count_next = count;
      unique case ({push_ok, pop_ok})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Register the pointers and the occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
      end
   end

   // data_valid trails an accepted pop by one cycle, matching the memory's registered read port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_valid <= 1'b0;
      end else begin
         data_valid <= pop_ok;
      end
   end

   // The error flags latch any rejected request and hold until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (push & full) begin
            overflow_err <= 1'b1;
         end
         if (pop & empty) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule
